// File: rtl/uart_tx_arbiter.sv
// Packet-level round-robin arbiter sharing one UART TX core among N byte-stream
// requesters; a winner keeps the core until its `last` byte, or until the watchdog evicts it.
module uart_tx_arbiter #(
  parameter int N              = 4,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req_valid_i,
  input  logic [8*N-1:0] req_data_i,
  input  logic [N-1:0]   req_last_i,
  output logic [N-1:0]   req_ready_o,
  output logic [N-1:0]   grant_o,
  output logic [7:0]     tx_data_o,
  output logic           tx_start_o,
  input  logic           tx_done_i,
  output logic           busy_o,
  output logic           timeout_err_o,
  output logic [1:0]     state_o
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_FETCH     = 2'd1;
  localparam logic [1:0] ST_WAIT_DONE = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [N-1:0]  grant_q, grant_d;
  logic [IW-1:0] gidx_q, gidx_d;
  logic [IW-1:0] last_ptr_q, last_ptr_d;
  logic [7:0]    tx_data_q, tx_data_d;
  logic          tx_start_q, tx_start_d;
  logic          last_r_q, last_r_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          timeout_q, timeout_d;

  logic          pick_found;
  logic [IW-1:0] pick_idx;
  logic [IW-1:0] cand;
  logic          hs;

  // Search starts just past the previous owner so every requester gets a turn.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int k = 1; k <= N; k++) begin
      cand = IW'((int'(last_ptr_q) + k) % N);
      if (!pick_found && req_valid_i[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  // valid/ready: a byte moves from requester i on a rising edge where
  // req_valid_i[i] && req_ready_o[i]; ready only ever rises for the owner in FETCH.
  assign req_ready_o = (state_q == ST_FETCH) ? (req_valid_i & grant_q) : '0;
  assign hs          = (state_q == ST_FETCH) && req_valid_i[gidx_q];

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    gidx_d     = gidx_q;
    last_ptr_d = last_ptr_q;
    tx_data_d  = tx_data_q;
    tx_start_d = 1'b0;
    last_r_d   = last_r_q;
    cnt_d      = cnt_q;
    timeout_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pick_found) begin
          grant_d = {{(N-1){1'b0}}, 1'b1} << pick_idx;
          gidx_d  = pick_idx;
          cnt_d   = '0;
          state_d = ST_FETCH;
        end
      end
      ST_FETCH: begin
        if (hs) begin
          tx_data_d  = req_data_i[{gidx_q, 3'b000} +: 8];
          last_r_d   = req_last_i[gidx_q];
          tx_start_d = 1'b1;
          state_d    = ST_WAIT_DONE;
        end else if ((TIMEOUT_CYCLES != 0) && (cnt_q == CW'(TIMEOUT_CYCLES - 1))) begin
          // This idle cycle would bring the count to the limit: evict now.
          timeout_d  = 1'b1;
          grant_d    = '0;
          last_ptr_d = gidx_q;
          state_d    = ST_IDLE;
        end else if (cnt_q != {CW{1'b1}}) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_WAIT_DONE: begin
        if (tx_done_i) begin
          if (last_r_q) begin
            grant_d    = '0;
            last_ptr_d = gidx_q;
            state_d    = ST_IDLE;
          end else begin
            cnt_d   = '0;
            state_d = ST_FETCH;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      grant_q    <= '0;
      gidx_q     <= '0;
      last_ptr_q <= IW'(N - 1);
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
      last_r_q   <= 1'b0;
      cnt_q      <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      gidx_q     <= gidx_d;
      last_ptr_q <= last_ptr_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= tx_start_d;
      last_r_q   <= last_r_d;
      cnt_q      <= cnt_d;
      timeout_q  <= timeout_d;
    end
  end

  assign grant_o       = grant_q;
  assign tx_data_o     = tx_data_q;
  assign tx_start_o    = tx_start_q;
  assign busy_o        = (state_q != ST_IDLE);
  assign timeout_err_o = timeout_q;
  assign state_o       = state_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed scenarios plus random packet mixes checked
// against a packet-level round-robin model and a behavioural TX core.
module tb_uart_tx_arbiter;
  localparam int N  = 4;
  localparam int TO = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst;
  logic [N-1:0]   req_valid, req_last, req_ready, grant;
  logic [8*N-1:0] req_data;
  logic [7:0]     tx_data;
  logic           tx_start, tx_done, busy, timeout_err;
  logic [1:0]     state;

  uart_tx_arbiter #(.N(N), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid), .req_data_i(req_data), .req_last_i(req_last),
    .req_ready_o(req_ready), .grant_o(grant),
    .tx_data_o(tx_data), .tx_start_o(tx_start), .tx_done_i(tx_done),
    .busy_o(busy), .timeout_err_o(timeout_err), .state_o(state)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  // Requester sources: {last, data} per byte.
  logic [8:0]  src_mem [N][64];
  int          src_rd [N];
  int          src_wr [N];
  int          m_rd [N];
  int          m_ptr;
  logic [N-1:0] en;

  // Expected transmit stream: {requester, last, data}.
  logic [10:0] exp_q[$];

  int done_at = -1, any_done_cyc = -1, last_done_cyc = -1;
  int lat_lo = 10, lat_hi = 10;
  bit inject_done = 1'b0;
  bit inflight_valid = 1'b0, inflight_last = 1'b0;
  int n_start = 0, n_timeout = 0, timeout_cyc = -1;
  logic [N-1:0] timeout_grant = '0;
  logic [N-1:0] prev_grant = '0;
  int rise_idx[$];
  int rise_cyc[$];
  bit gap_en = 1'b0, hold_en = 1'b0, guard0 = 1'b0;
  logic [N-1:0] hold_grant = '0;
  int hold_bad = 0, bad0 = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int idx_of(input logic [N-1:0] g);
    for (int i = 0; i < N; i++) if (g[i]) return i;
    return -1;
  endfunction

  function automatic bit all_drained();
    for (int i = 0; i < N; i++) if (src_rd[i] != src_wr[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic load_byte(input int i, input logic last, input logic [7:0] data);
    src_mem[i][src_wr[i]] = {last, data};
    src_wr[i]++;
  endtask

  // Reference: owner is the first requester past the previous owner that has
  // bytes pending; it sends its whole packet (or whatever it has) before anyone else.
  function automatic bit model_next(input logic [N-1:0] mask);
    for (int k = 1; k <= N; k++) begin
      int  i;
      bit  end_pkt;
      i = (m_ptr + k) % N;
      if (mask[i] && m_rd[i] < src_wr[i]) begin
        end_pkt = 1'b0;
        while (!end_pkt && m_rd[i] < src_wr[i]) begin
          exp_q.push_back({2'(i), src_mem[i][m_rd[i]]});
          end_pkt = src_mem[i][m_rd[i]][8];
          m_rd[i]++;
        end
        m_ptr = i;
        return 1'b1;
      end
    end
    return 1'b0;
  endfunction

  task automatic clear_bench();
    for (int i = 0; i < N; i++) begin
      src_rd[i] = 0;
      src_wr[i] = 0;
      m_rd[i]   = 0;
    end
    en = '0;
    exp_q.delete();
    m_ptr = N - 1;
    inflight_valid = 1'b0;
  endtask

  // One clock: observe registered outputs, drive inputs, then observe ready.
  task automatic tick();
    logic [10:0] e;
    @(posedge clk);
    #1;
    cyc++;
    if (tx_start) begin
      n_start++;
      checks++;
      assert (exp_q.size() != 0) else begin
        errors++;
        $error("FAIL start_unexpected observed=%0h expected=none", tx_data);
      end
      inflight_valid = 1'b0;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("tx_byte", {grant, tx_data}, {4'(1) << e[10:9], e[7:0]});
        inflight_valid = 1'b1;
        inflight_last  = e[8];
      end
      done_at = cyc + int'($urandom_range(lat_hi, lat_lo));
    end
    if (timeout_err) begin
      n_timeout++;
      timeout_cyc   = cyc;
      timeout_grant = grant;
    end
    if (prev_grant == '0 && grant != '0) begin
      rise_idx.push_back(idx_of(grant));
      rise_cyc.push_back(cyc);
      if (gap_en && last_done_cyc >= 0) check("grant_gap", cyc - last_done_cyc, 2);
    end
    if (hold_en && busy && grant !== hold_grant) hold_bad++;
    prev_grant = grant;

    tx_done = inject_done || (cyc == done_at);
    if (cyc == done_at) begin
      any_done_cyc = cyc;
      if (inflight_valid && inflight_last) last_done_cyc = cyc;
      inflight_valid = 1'b0;
    end
    inject_done = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (en[i] && src_rd[i] < src_wr[i]) begin
        req_valid[i]       = 1'b1;
        req_last[i]        = src_mem[i][src_rd[i]][8];
        req_data[8*i +: 8] = src_mem[i][src_rd[i]][7:0];
      end else begin
        req_valid[i]       = 1'b0;
        req_last[i]        = 1'b0;
        req_data[8*i +: 8] = 8'h00;
      end
    end
    #1;
    if (guard0 && (req_ready[0] || grant[0])) bad0++;
    for (int i = 0; i < N; i++) if (req_valid[i] && req_ready[i]) src_rd[i]++;
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    clear_bench();
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic run_drain(input int budget, input string tag);
    int b;
    b = 0;
    while (b < budget && !(exp_q.size() == 0 && !busy && cyc > done_at && all_drained())) begin
      tick();
      b++;
    end
    check({tag, "_drain"}, b < budget, 1);
    check({tag, "_exp_left"}, exp_q.size(), 0);
  endtask

  initial begin
    int b, t, s, npk, len;
    rst = 1'b1;
    tx_done = 1'b0;
    req_valid = '0;
    req_last = '0;
    req_data = '0;
    clear_bench();

    // Reset values, with every requester asserting valid.
    for (int i = 0; i < N; i++) load_byte(i, 1'b1, 8'(8'hA0 + i));
    en = '1;
    tick();
    tick();
    check("rst_grant", grant, 0);
    check("rst_busy", busy, 0);
    check("rst_tx_start", tx_start, 0);
    check("rst_tx_data", tx_data, 0);
    check("rst_timeout", timeout_err, 0);
    check("rst_ready", req_ready, 0);
    check("rst_state", state, 0);
    reset_dut();

    // Single requester, three-byte packet.
    lat_lo = 10; lat_hi = 10;
    load_byte(2, 1'b0, 8'h41);
    load_byte(2, 1'b0, 8'h42);
    load_byte(2, 1'b1, 8'h43);
    en = 4'b0100;
    void'(model_next(4'b0100));
    hold_grant = 4'b0100; hold_en = 1'b1; hold_bad = 0; n_start = 0;
    run_drain(200, "t1");
    hold_en = 1'b0;
    check("t1_grant_held", hold_bad, 0);
    check("t1_starts", n_start, 3);
    check("t1_grant_end", grant, 0);
    check("t1_busy_end", busy, 0);

    // All requesters, 1-byte packets twice: strict rotation, 2-cycle regrant.
    reset_dut();
    lat_lo = 3; lat_hi = 8;
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < N; i++) load_byte(i, 1'b1, 8'($urandom));
    en = '1;
    for (int k = 0; k < 8; k++) void'(model_next('1));
    rise_idx.delete(); rise_cyc.delete();
    last_done_cyc = -1; gap_en = 1'b1;
    run_drain(400, "t2");
    gap_en = 1'b0;
    check("t2_rises", rise_idx.size(), 8);
    for (int k = 0; k < 8 && k < rise_idx.size(); k++) check("t2_order", rise_idx[k], k % 4);

    // Requester 0 arrives mid-packet of requester 1.
    reset_dut();
    lat_lo = 6; lat_hi = 6;
    for (int j = 0; j < 4; j++) load_byte(1, j == 3, 8'(8'h10 + j));
    load_byte(0, 1'b1, 8'h77);
    en = 4'b0010;
    void'(model_next(4'b0010));
    rise_idx.delete(); rise_cyc.delete();
    last_done_cyc = -1; n_start = 0; bad0 = 0; guard0 = 1'b1;
    b = 0;
    while (n_start < 2 && b < 200) begin tick(); b++; end
    check("t3_two_sent", n_start, 2);
    en = 4'b0011;
    void'(model_next(4'b0011));
    b = 0;
    while (last_done_cyc < 0 && b < 200) begin tick(); b++; end
    check("t3_req1_done", last_done_cyc >= 0, 1);
    guard0 = 1'b0;
    check("t3_no_ready0", bad0, 0);
    run_drain(200, "t3");
    check("t3_rises", rise_idx.size(), 2);
    check("t3_first", rise_idx.size() >= 1 ? rise_idx[0] : -1, 1);
    check("t3_next", rise_idx.size() >= 2 ? rise_idx[1] : -1, 0);

    // Watchdog eviction of requester 3; requester 0 waiting.
    reset_dut();
    lat_lo = 5; lat_hi = 5;
    load_byte(3, 1'b0, 8'h5A);
    load_byte(0, 1'b1, 8'h66);
    en = 4'b1000;
    void'(model_next(4'b1000));
    any_done_cyc = -1; n_timeout = 0; timeout_cyc = -1;
    rise_idx.delete(); rise_cyc.delete();
    b = 0;
    while (any_done_cyc < 0 && b < 100) begin tick(); b++; end
    t = any_done_cyc;
    en = 4'b1001;
    void'(model_next(4'b1001));
    run_drain(200, "t4");
    check("t4_timeouts", n_timeout, 1);
    check("t4_timeout_cyc", timeout_cyc, t + 1 + TO);
    check("t4_timeout_grant", timeout_grant, 0);
    check("t4_rises", rise_idx.size(), 2);
    check("t4_regrant_idx", rise_idx.size() >= 2 ? rise_idx[1] : -1, 0);
    check("t4_regrant_cyc", rise_cyc.size() >= 2 ? rise_cyc[1] : -1, t + TO + 2);

    // Reset one cycle after a start; stray done must be ignored.
    reset_dut();
    lat_lo = 10; lat_hi = 10;
    for (int j = 0; j < 3; j++) load_byte(1, j == 2, 8'(8'h31 + j));
    en = 4'b0010;
    void'(model_next(4'b0010));
    n_start = 0;
    b = 0;
    while (n_start < 1 && b < 100) begin tick(); b++; end
    s = cyc;
    tick();
    rst = 1'b1;
    clear_bench();
    tick();
    check("t5_rst_cyc", cyc, s + 2);
    check("t5_grant", grant, 0);
    check("t5_busy", busy, 0);
    check("t5_tx_start", tx_start, 0);
    check("t5_tx_data", tx_data, 0);
    check("t5_timeout", timeout_err, 0);
    check("t5_ready", req_ready, 0);
    rst = 1'b0;
    b = 0;
    while (cyc <= done_at && b < 50) begin tick(); b++; end
    check("t5_stray_busy", busy, 0);
    check("t5_stray_grant", grant, 0);
    check("t5_stray_starts", n_start, 1);
    load_byte(2, 1'b1, 8'h52);
    load_byte(0, 1'b1, 8'h50);
    en = 4'b0101;
    void'(model_next(4'b0101));
    void'(model_next(4'b0101));
    rise_idx.delete(); rise_cyc.delete();
    run_drain(200, "t5");
    check("t5_first_after_rst", rise_idx.size() >= 1 ? rise_idx[0] : -1, 0);

    // Spurious tx_done in IDLE and in FETCH.
    reset_dut();
    lat_lo = 10; lat_hi = 10;
    n_start = 0; n_timeout = 0;
    inject_done = 1'b1;
    tick();
    tick();
    check("t6_idle_busy", busy, 0);
    check("t6_idle_grant", grant, 0);
    check("t6_idle_start", tx_start, 0);
    load_byte(0, 1'b0, 8'h61);
    load_byte(0, 1'b1, 8'h62);
    en = 4'b0001;
    void'(model_next(4'b0001));
    any_done_cyc = -1;
    b = 0;
    while (n_start < 1 && b < 100) begin tick(); b++; end
    en = 4'b0000;
    b = 0;
    while (any_done_cyc < 0 && b < 100) begin tick(); b++; end
    inject_done = 1'b1;
    tick();
    inject_done = 1'b1;
    tick();
    tick();
    check("t6_fetch_busy", busy, 1);
    check("t6_fetch_grant", grant, 4'b0001);
    check("t6_fetch_starts", n_start, 1);
    check("t6_fetch_start", tx_start, 0);
    en = 4'b0001;
    run_drain(200, "t6");
    check("t6_starts", n_start, 2);
    check("t6_no_timeout", n_timeout, 0);

    // Random packet mixes with random TX latency.
    for (int r = 0; r < 3; r++) begin
      reset_dut();
      lat_lo = 1; lat_hi = 6;
      for (int i = 0; i < N; i++) begin
        npk = int'($urandom_range(3, 0));
        for (int p = 0; p < npk; p++) begin
          len = int'($urandom_range(4, 1));
          for (int j = 0; j < len; j++) load_byte(i, j == len - 1, 8'($urandom));
        end
      end
      en = '1;
      while (model_next('1)) begin end
      run_drain(1500, "t7");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
